// File: rtl/voltmeter_pkg.sv
// ---------------------------------------------------------------------------
// voltmeter_pkg
// Shared constants for the on-screen voltmeter data path:
//   - NCH          : number of XADC channels scanned per pass (fixed at 13)
//   - MV_SENTINEL  : value stored for a channel whose DRP read timed out
//   - CH_ADDR      : DRP register address per channel index
//                    (VP/VN first, then VAUX0..VAUX11)
//   - ST_*         : scan FSM state encoding
//   - ch_addr()    : guarded table lookup, 7'h00 for out-of-range indices
// ---------------------------------------------------------------------------
package voltmeter_pkg;

  localparam int NCH = 13;

  localparam logic [9:0] MV_SENTINEL = 10'h3FF;

  localparam logic [3:0] LAST_CH = 4'd12;

  localparam logic [6:0] CH_ADDR [NCH] = '{
    7'h03,
    7'h10, 7'h11, 7'h12, 7'h13,
    7'h14, 7'h15, 7'h16, 7'h17,
    7'h18, 7'h19, 7'h1A, 7'h1B
  };

  // Scan FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CONV  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;

  // DRP address for a channel; indices past the last channel map to 0.
  function automatic logic [6:0] ch_addr(input logic [3:0] ch);
    logic [6:0] addr;
    if (ch <= LAST_CH) begin
      addr = CH_ADDR[ch];
    end else begin
      addr = 7'h00;
    end
    return addr;
  endfunction

endpackage

// File: rtl/code_to_mv.sv
// ---------------------------------------------------------------------------
// code_to_mv
// Converts a 12-bit XADC code to millivolts on a 0..999 scale:
//   mv = (code * 1000) >> 12   (22-bit product, truncating shift)
// One register stage; the result is valid one clock after code_i.
// Kept separate so range/scale variants can swap the multiplier.
//
// Ports:
//   clk_i   in   1   clock
//   rst_ni  in   1   asynchronous active-low reset
//   code_i  in  12   raw ADC code
//   mv_o    out 10   registered millivolt value
// ---------------------------------------------------------------------------
module code_to_mv (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] code_i,
  output logic [9:0]  mv_o
);

  logic [9:0] mv_d;
  logic [9:0] mv_q;

  // Scale the code; the maximum 0xFFF yields 999, so 10 bits always suffice.
  always_comb begin
    mv_d = 10'((22'(code_i) * 22'd1000) >> 12);
  end

  // Output register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mv_q <= 10'd0;
    end else begin
      mv_q <= mv_d;
    end
  end

  assign mv_o = mv_q;

endmodule

// File: rtl/adc_scan_buffer.sv
// ---------------------------------------------------------------------------
// adc_scan_buffer
// Periodically reads 13 XADC channels over DRP, converts each code to
// millivolts and keeps the latest value per channel for the character
// overlay, which reads it back through a registered random-access port.
//
// Parameters:
//   SCAN_DIV  pclk cycles between scan starts (16 .. 2^24-1)
//   TIMEOUT   pclk cycles to wait for drdy before failing a channel (4..255)
//
// Ports:
//   pclk       in    1  pixel clock, the only clock
//   rst        in    1  asynchronous active-low reset
//   drp_den    out   1  DRP enable, one-cycle pulse per read
//   drp_daddr  out   7  DRP register address
//   drp_dwe    out   1  DRP write enable, always 0
//   drp_drdy   in    1  DRP data ready
//   drp_do     in   16  DRP read data, code in [15:4]
//   rd_ch      in    4  channel index from the display stage
//   rd_mv      out  10  millivolts for rd_ch, one-cycle latency
//   rd_err     out   1  timeout flag for rd_ch, same timing as rd_mv
//   scan_done  out   1  one-cycle pulse while the last channel is stored
//   busy       out   1  high from scan start until scan_done
// ---------------------------------------------------------------------------
module adc_scan_buffer
  import voltmeter_pkg::*;
#(
  parameter int SCAN_DIV = 4_000_000,
  parameter int TIMEOUT  = 64
) (
  input  logic        pclk,
  input  logic        rst,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  input  logic [3:0]  rd_ch,
  output logic [9:0]  rd_mv,
  output logic        rd_err,
  output logic        scan_done,
  output logic        busy
);

  localparam logic [23:0] TICK_LAST = 24'(SCAN_DIV - 1);
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);

  // Scan control state
  logic [2:0]  state_q,    state_d;
  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  ch_q,       ch_d;
  logic [7:0]  tmo_cnt_q,  tmo_cnt_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [11:0] code_q,     code_d;
  logic        tick_s;

  // Registered DRP / status outputs
  logic        den_q,   den_d;
  logic [6:0]  daddr_q, daddr_d;
  logic        done_q,  done_d;
  logic        busy_q,  busy_d;

  // Channel buffer and read port
  logic [9:0]     mv_buf_q [NCH];
  logic [NCH-1:0] err_q;
  logic [9:0]     rd_mv_q;
  logic           rd_err_q;
  logic [9:0]     mv_s;

  code_to_mv u_code_to_mv (
    .clk_i  (pclk),
    .rst_ni (rst),
    .code_i (code_q),
    .mv_o   (mv_s)
  );

  // Free-running scan period counter; tick marks the terminal count.
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) begin
      tick_cnt_d = 24'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 24'd1;
    end
  end

  // Scan FSM next-state logic
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    code_d     = code_q;
    case (state_q)
      ST_IDLE: begin
        // A tick arriving while a scan is running is simply lost.
        if (tick_s) begin
          state_d = ST_REQ;
          ch_d    = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Re-arm the wait so a stale drdy/timeout cannot leak across channels.
        tmo_cnt_d  = 8'd0;
        tmo_flag_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          code_d  = 12'(drp_do >> 4);
          state_d = ST_CONV;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          state_d    = ST_STORE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_CONV: begin
        // code_to_mv registers the result on this edge.
        state_d = ST_STORE;
      end
      ST_STORE: begin
        if (ch_q == LAST_CH) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + 4'd1;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-values, decoded from the state being entered so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    den_d = (state_d == ST_REQ);
    if (den_d) begin
      daddr_d = ch_addr(ch_d);
    end else begin
      daddr_d = daddr_q;
    end
    done_d = (state_d == ST_STORE) && (ch_q == LAST_CH);
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 24'd0;
      ch_q       <= 4'd0;
      tmo_cnt_q  <= 8'd0;
      tmo_flag_q <= 1'b0;
      code_q     <= 12'd0;
      den_q      <= 1'b0;
      daddr_q    <= 7'h00;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ch_q       <= ch_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
      code_q     <= code_d;
      den_q      <= den_d;
      daddr_q    <= daddr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Channel buffer: written once per channel in STORE.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        mv_buf_q[i] <= 10'd0;
      end
      err_q <= {NCH{1'b0}};
    end else if (state_q == ST_STORE) begin
      if (tmo_flag_q) begin
        mv_buf_q[ch_q] <= MV_SENTINEL;
        err_q[ch_q]    <= 1'b1;
      end else begin
        mv_buf_q[ch_q] <= mv_s;
        err_q[ch_q]    <= 1'b0;
      end
    end else begin
      err_q <= err_q;
    end
  end

  // Registered read port; a same-cycle STORE is seen one cycle later.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rd_mv_q  <= 10'd0;
      rd_err_q <= 1'b0;
    end else if (rd_ch <= LAST_CH) begin
      rd_mv_q  <= mv_buf_q[rd_ch];
      rd_err_q <= err_q[rd_ch];
    end else begin
      rd_mv_q  <= 10'd0;
      rd_err_q <= 1'b0;
    end
  end

  assign drp_den   = den_q;
  assign drp_daddr = daddr_q;
  assign drp_dwe   = 1'b0;
  assign rd_mv     = rd_mv_q;
  assign rd_err    = rd_err_q;
  assign scan_done = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc_scan_buffer.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_buffer
// Scoreboard bench: the main thread queues expected DRP addresses and read
// results; a monitor pops and compares whenever the DUT pulses drp_den or a
// read result becomes due. A small DRP model answers each den after a
// programmable delay with a per-address response table.
// ---------------------------------------------------------------------------
module tb_adc_scan_buffer;

  localparam int SCAN_DIV = 32;
  localparam int TIMEOUT  = 64;

  logic        pclk = 1'b0;
  logic        rst;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_dwe;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do   = 16'h0000;
  logic [3:0]  rd_ch    = 4'd0;
  logic [9:0]  rd_mv;
  logic        rd_err;
  logic        scan_done;
  logic        busy;

  adc_scan_buffer #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .drp_den   (drp_den),
    .drp_daddr (drp_daddr),
    .drp_dwe   (drp_dwe),
    .drp_drdy  (drp_drdy),
    .drp_do    (drp_do),
    .rd_ch     (rd_ch),
    .rd_mv     (rd_mv),
    .rd_err    (rd_err),
    .scan_done (scan_done),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [3:0] ch;
    logic [9:0] mv;
    logic       err;
  } rd_exp_t;

  int         tests_run = 0;
  int         fails     = 0;
  int         cyc       = 0;
  int         den_cnt   = 0;
  int         done_cnt  = 0;
  int         busy_rises = 0;
  int         last_den_cyc = 0;
  logic [6:0] last_den_addr = 7'h00;
  int         den_cyc [128];
  logic [6:0] den_q [$];
  rd_exp_t    rd_q [$];
  logic       rd_issue = 1'b0;

  logic        answer [128];
  logic [15:0] resp   [128];
  int          dly = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_scan();
    den_q.push_back(7'h03);
    for (int i = 0; i < 12; i++) begin
      den_q.push_back(7'(16 + i));
    end
  endtask

  task automatic set_all(input logic [15:0] code);
    for (int i = 0; i < 128; i++) begin
      answer[i] = 1'b1;
      resp[i]   = code;
    end
  endtask

  // Issue one read at a negedge; the monitor checks it after the next posedge.
  task automatic rd(input logic [3:0] ch, input logic [9:0] mv, input logic err);
    rd_exp_t e;
    e.ch = ch; e.mv = mv; e.err = err;
    rd_ch = ch;
    rd_q.push_back(e);
    rd_issue = 1'b1;
    @(negedge pclk);
    rd_issue = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("scan_done_seen", done_cnt - start, 1);
  endtask

  task automatic wait_den(input int budget);
    int start;
    int n;
    start = den_cnt;
    n = 0;
    while (den_cnt == start && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("den_seen", (den_cnt != start) ? 1 : 0, 1);
  endtask

  // DRP responder: answers after dly cycles unless the address is muted.
  initial begin
    logic [6:0] a;
    forever begin
      @(posedge pclk);
      #1;
      if (drp_den === 1'b1) begin
        a = drp_daddr;
        if (answer[a]) begin
          repeat (dly) @(posedge pclk);
          #1;
          drp_drdy = 1'b1;
          drp_do   = resp[a];
          @(posedge pclk);
          #1;
          drp_drdy = 1'b0;
          drp_do   = 16'h0000;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       iss;
    logic       busy_prev;
    logic [6:0] ea;
    rd_exp_t    e;
    busy_prev = 1'b0;
    forever begin
      @(posedge pclk);
      cyc++;
      iss = rd_issue;
      #1;
      if (drp_den === 1'b1) begin
        den_cnt++;
        last_den_cyc  = cyc;
        last_den_addr = drp_daddr;
        den_cyc[drp_daddr] = cyc;
        if (den_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_den: got addr 0x%0h, expected no request", drp_daddr);
        end else begin
          ea = den_q.pop_front();
          check("den_addr", drp_daddr, ea);
          check("den_dwe", drp_dwe, 0);
        end
      end
      if (iss) begin
        if (rd_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL rd_queue: read result due but nothing expected");
        end else begin
          e = rd_q.pop_front();
          check($sformatf("rd_mv_ch%0d", e.ch), rd_mv, e.mv);
          check($sformatf("rd_err_ch%0d", e.ch), rd_err, e.err);
        end
      end
      if (scan_done === 1'b1) begin
        done_cnt++;
        check("busy_at_done", busy, 1);
      end
      if (busy === 1'b1 && busy_prev == 1'b0) begin
        busy_rises++;
      end
      busy_prev = busy;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    int rel;
    int rises_b;
    int n;
    set_all(16'h8000);
    dly = 2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (3) @(negedge pclk);

    // Reset state
    check("rst_den", drp_den, 0);
    check("rst_daddr", drp_daddr, 0);
    check("rst_dwe", drp_dwe, 0);
    check("rst_rd_mv", rd_mv, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);

    // Scan A: every channel returns 0x800 -> 500 mV
    rst = 1'b1;
    rel = cyc;
    push_scan();
    wait_den(200);
    check("first_den_delay", last_den_cyc - rel, SCAN_DIV);
    wait_done(2000);
    push_scan();
    // Configure scan B: endpoints, muted ch6, ch7 = 0xC00 -> 750
    set_all(16'h8000);
    resp[7'h03] = 16'h0000;
    resp[7'h10] = 16'hFFF0;
    resp[7'h11] = 16'h0010;
    answer[7'h15] = 1'b0;
    resp[7'h16] = 16'hC000;
    for (int c = 0; c < 13; c++) begin
      rd(4'(c), 10'd500, 1'b0);
    end
    rd(4'd13, 10'd0, 1'b0);
    rd(4'd15, 10'd0, 1'b0);

    // Scan B results
    wait_done(2000);
    push_scan();
    check("timeout_den_gap", den_cyc[7'h16] - den_cyc[7'h15], TIMEOUT + 2);
    rises_b = busy_rises;
    // Configure scan C: slow DRP, ch6 answers 0x400, ch12 0xFFF
    set_all(16'h8000);
    resp[7'h15] = 16'h4000;
    resp[7'h1B] = 16'hFFF0;
    dly = 10;
    rd(4'd0, 10'd0, 1'b0);
    rd(4'd1, 10'd999, 1'b0);
    rd(4'd2, 10'd0, 1'b0);
    rd(4'd6, 10'd1023, 1'b1);
    rd(4'd7, 10'd750, 1'b0);
    rd(4'd3, 10'd500, 1'b0);

    // Scan C: longer than SCAN_DIV, ticks are dropped
    wait_done(2000);
    push_scan();
    check("busy_continuous_scanC", busy_rises - rises_b, 1);
    set_all(16'h8000);
    dly = 2;
    // First read lands on the same edge as ch12's store: old value first.
    rd(4'd12, 10'd500, 1'b0);
    rd(4'd12, 10'd999, 1'b0);
    rd(4'd6, 10'd250, 1'b0);
    rd(4'd0, 10'd500, 1'b0);

    // Scan D: reset while ch5 is being requested
    n = 0;
    while (last_den_addr != 7'h14 && n < 500) begin
      @(negedge pclk);
      n++;
    end
    check("reached_ch5", last_den_addr, 7'h14);
    rst = 1'b0;
    #1;
    check("midrst_den", drp_den, 0);
    check("midrst_daddr", drp_daddr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_mv", rd_mv, 0);
    check("midrst_rd_err", rd_err, 0);
    check("midrst_scan_done", scan_done, 0);
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    rel = cyc;
    den_q.delete();
    push_scan();
    rd(4'd0, 10'd0, 1'b0);
    rd(4'd4, 10'd0, 1'b0);
    wait_den(200);
    check("post_rst_den_delay", last_den_cyc - rel, SCAN_DIV);
    wait_done(2000);
    push_scan();
    rd(4'd0, 10'd500, 1'b0);
    rd(4'd5, 10'd500, 1'b0);
    rd(4'd12, 10'd500, 1'b0);
    @(negedge pclk);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
